csr_arbiter: RTL and testbench
==============================

CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive denied cycles before the debug requester is promoted.
REQ-002 SHALL have parameter LOCK_MAX, default 16: maximum cycles one owner may hold a lock.
REQ-003 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports {cl,ex,dbg}_req_i, input, 1 each, access request from clint, ex, and jtag debug.
REQ-006 SHALL have ports {cl,ex,dbg}_we_i, input, 1 each, write (1) or read (0).
REQ-007 SHALL have ports {cl,ex,dbg}_addr_i, input, 32 each, CSR address; bits [11:0] significant.
REQ-008 SHALL have ports {cl,ex,dbg}_wdata_i, input, 32 each, write data.
REQ-009 SHALL have port cl_lock_i, input, 1, clint holds ownership across cycles (trap entry/exit sequence).
REQ-010 SHALL have ports {cl,ex,dbg}_gnt_o, output, 1 each, access performed this cycle.
REQ-011 SHALL have port rdata_o, output, 32, read data for the granted requester, valid when its gnt is high.
REQ-012 SHALL have ports csr_we_o (output, 1), csr_waddr_o (output, 32), csr_raddr_o (output, 32) and csr_wdata_o (output, 32), the single CSR register-file port.
REQ-013 SHALL have port csr_rdata_i, input, 32, register-file read data.
REQ-014 SHALL have port lock_err_o, output, 1, sticky flag set on lock timeout.

Function
REQ-015 At most one gnt SHALL be high per cycle; gnt is combinational from the current req and state.
REQ-016 In state IDLE, priority SHALL be clint > ex > dbg, except when promote is set: then dbg > clint > ex.
REQ-017 The granted requester's we, addr and wdata SHALL drive the csr_* outputs in the same cycle. csr_raddr_o and csr_waddr_o SHALL both equal its addr.
REQ-018 With no grant, csr_we_o SHALL be 0 and the address/data outputs SHALL be 0.
REQ-019 rdata_o SHALL equal csr_rdata_i when any gnt is high, else 0.
REQ-020 A clint grant with cl_lock_i=1 SHALL move the FSM IDLE->LOCKED at the next edge.
REQ-021 In LOCKED, only clint SHALL be grantable. ex and dbg requests SHALL wait; ex and dbg gnt stay 0 even when cl_req_i=0.
REQ-022 LOCKED->IDLE SHALL occur at the edge where cl_lock_i=0, or where lock_cnt reaches LOCK_MAX-1.
REQ-023 lock_cnt SHALL clear on entering LOCKED and increment each LOCKED cycle.
REQ-024 On timeout, lock_err_o SHALL set and stay set until reset. The FSM then returns to IDLE; clint must drop and re-assert lock to lock again.
REQ-025 starve_cnt (width clog2(STARVE_LIMIT)+1) SHALL increment each cycle dbg_req_i=1 and dbg_gnt_o=0, and clear on dbg grant or dbg_req_i=0.
REQ-026 starve_cnt SHALL saturate at STARVE_LIMIT.
REQ-027 promote SHALL equal (starve_cnt == STARVE_LIMIT) and SHALL have effect only in IDLE.
REQ-028 Requests dropped before grant SHALL be discarded with no side effect.

Reset
REQ-029 On rst=0, FSM=IDLE, lock_cnt=0, starve_cnt=0 and lock_err_o=0 SHALL apply asynchronously.
REQ-030 While rst=0, all gnt, csr_we_o and address/data/rdata outputs SHALL read 0.
REQ-031 Reset asserted mid-lock SHALL abandon the sequence. The first cycle after release is IDLE with normal priority.

Structure
REQ-032 State encodings (IDLE, LOCKED) and requester index constants SHALL live in the shared defines file, alongside the CSR address defines.
REQ-033 The starvation counter/promote logic SHALL be one sub-module, csr_arb_starve. The FSM and muxing SHALL stay in csr_arbiter.
REQ-034 csr_arbiter SHALL sit between clint/ex/jtag and the CSR register file, replacing their direct connections.

Verification
REQ-035 Bench SHALL cover: cl, ex and dbg all request writes to mtvec in one cycle -> cl_gnt=1, csr_wdata_o = the clint data, the other gnts 0.
REQ-036 Bench SHALL cover: clint writes mepc, mcause, mstatus on 3 consecutive cycles with lock=1 while ex requests -> ex_gnt=0 for 3 cycles, then ex granted the cycle after lock drops.
REQ-037 Bench SHALL cover: ex requests every cycle while dbg requests -> dbg_gnt=1 on the 9th cycle (STARVE_LIMIT=8), then ex regains priority.
REQ-038 Bench SHALL cover: clint holds lock=1 for 20 cycles -> lock_err_o rises after the 16th LOCKED cycle, ex granted the next cycle, flag stays until rst.
REQ-039 Bench SHALL cover: ex reads mscratch holding 0xDEADBEEF -> rdata_o=0xDEADBEEF with ex_gnt=1 in the same cycle.
REQ-040 Bench SHALL cover: rst asserted asynchronously during LOCKED -> gnts 0 immediately, FSM IDLE after release.

Source files
------------

// File: rtl/csr_arbiter_pkg.sv
// Shared CSR arbiter definitions: FSM state codes, requester indices, CSR addresses.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package csr_arbiter_pkg;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Requester indices into the grant vector
    localparam int REQ_CL  = 0;
    localparam int REQ_EX  = 1;
    localparam int REQ_DBG = 2;
    localparam int NUM_REQ = 3;

    // Machine-mode CSR addresses (bits [11:0])
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    // One requester's access, as presented to the register-file port
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } csr_req_t;

endpackage

// File: rtl/csr_arb_starve.sv
// Debug starvation tracker: counts consecutive denied debug cycles, raises promote at the limit.
// Latency: promote is registered, reflects denials up to the previous edge.
// Backpressure: none; observes dbg request/grant only.
//
// Ports: clk, rst (async active-low), dbg_req, dbg_gnt in; promote out.
module csr_arb_starve
    import csr_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic promote
);

    localparam int            CW    = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign promote = (starve_cnt == LIMIT);

endmodule

// File: rtl/csr_arbiter.sv
// Arbitrates clint / ex / jtag-debug onto the single CSR register-file port, with clint lock.
// Latency: 0 cycles; grant and csr_* outputs are combinational from req and state.
// Backpressure: a requester holds req until its gnt; losers and lock-blocked requests wait.
//
// Ports: clk, rst (async active-low); {cl,ex,dbg}_{req,we,addr,wdata}_i requester side,
//        cl_lock_i; {cl,ex,dbg}_gnt_o, rdata_o; csr_{we,waddr,raddr,wdata}_o, csr_rdata_i
//        register-file side; lock_err_o sticky lock-timeout flag.
module csr_arbiter
    import csr_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cl_req_i,
    input  logic        ex_req_i,
    input  logic        dbg_req_i,
    input  logic        cl_we_i,
    input  logic        ex_we_i,
    input  logic        dbg_we_i,
    input  logic [31:0] cl_addr_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] cl_wdata_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        cl_lock_i,
    output logic        cl_gnt_o,
    output logic        ex_gnt_o,
    output logic        dbg_gnt_o,
    output logic [31:0] rdata_o,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_raddr_o,
    output logic [31:0] csr_wdata_o,
    input  logic [31:0] csr_rdata_i,
    output logic        lock_err_o
);

    localparam int             LCW       = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);

    logic [0:0]         state;
    logic [LCW-1:0]     lock_cnt;
    logic               relock_blk;
    logic               promote;
    logic [NUM_REQ-1:0] gnt_vec;
    csr_req_t           req_dat [NUM_REQ];
    csr_req_t           sel;

    assign req_dat[REQ_CL]  = '{we: cl_we_i,  addr: cl_addr_i,  wdata: cl_wdata_i};
    assign req_dat[REQ_EX]  = '{we: ex_we_i,  addr: ex_addr_i,  wdata: ex_wdata_i};
    assign req_dat[REQ_DBG] = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};

    // Grant select. Reset gates everything so the port is quiet while rst is low,
    // regardless of what the requesters are driving.
    always_comb begin
        gnt_vec = '0;
        if (rst) begin
            if (state == ST_LOCKED) begin
                gnt_vec[REQ_CL] = cl_req_i;
            end else if (promote && dbg_req_i) begin
                gnt_vec[REQ_DBG] = 1'b1;
            end else if (cl_req_i) begin
                gnt_vec[REQ_CL] = 1'b1;
            end else if (ex_req_i) begin
                gnt_vec[REQ_EX] = 1'b1;
            end else if (dbg_req_i) begin
                gnt_vec[REQ_DBG] = 1'b1;
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) sel = req_dat[i];
        end
    end

    assign cl_gnt_o    = gnt_vec[REQ_CL];
    assign ex_gnt_o    = gnt_vec[REQ_EX];
    assign dbg_gnt_o   = gnt_vec[REQ_DBG];
    assign csr_we_o    = sel.we;
    assign csr_waddr_o = sel.addr;
    assign csr_raddr_o = sel.addr;
    assign csr_wdata_o = sel.wdata;
    assign rdata_o     = (|gnt_vec) ? csr_rdata_i : 32'h0;

    // Lock FSM. After a timeout, relock_blk stops the still-asserted cl_lock_i from
    // immediately re-locking; clint must drop lock once before it can lock again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lock_cnt   <= '0;
            lock_err_o <= 1'b0;
            relock_blk <= 1'b0;
        end else begin
            if (!cl_lock_i) relock_blk <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_vec[REQ_CL] && cl_lock_i && !relock_blk) begin
                        state    <= ST_LOCKED;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    if (!cl_lock_i) begin
                        state <= ST_IDLE;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state      <= ST_IDLE;
                        lock_err_o <= 1'b1;
                        relock_blk <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end
                end
            endcase
        end
    end

    csr_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .dbg_req (dbg_req_i),
        .dbg_gnt (gnt_vec[REQ_DBG]),
        .promote (promote)
    );

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter: priority, lock, starvation promotion, timeout, reset.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_csr_arbiter;
    import csr_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cl_req_i, ex_req_i, dbg_req_i;
    logic        cl_we_i, ex_we_i, dbg_we_i;
    logic [31:0] cl_addr_i, ex_addr_i, dbg_addr_i;
    logic [31:0] cl_wdata_i, ex_wdata_i, dbg_wdata_i;
    logic        cl_lock_i;
    logic        cl_gnt_o, ex_gnt_o, dbg_gnt_o;
    logic [31:0] rdata_o;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o, csr_raddr_o, csr_wdata_o;
    logic [31:0] csr_rdata_i;
    logic        lock_err_o;

    int n_pass  = 0;
    int n_total = 0;

    csr_arbiter #(.STARVE_LIMIT(8), .LOCK_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .cl_req_i(cl_req_i), .ex_req_i(ex_req_i), .dbg_req_i(dbg_req_i),
        .cl_we_i(cl_we_i), .ex_we_i(ex_we_i), .dbg_we_i(dbg_we_i),
        .cl_addr_i(cl_addr_i), .ex_addr_i(ex_addr_i), .dbg_addr_i(dbg_addr_i),
        .cl_wdata_i(cl_wdata_i), .ex_wdata_i(ex_wdata_i), .dbg_wdata_i(dbg_wdata_i),
        .cl_lock_i(cl_lock_i),
        .cl_gnt_o(cl_gnt_o), .ex_gnt_o(ex_gnt_o), .dbg_gnt_o(dbg_gnt_o),
        .rdata_o(rdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_raddr_o(csr_raddr_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
        .lock_err_o(lock_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, where new inputs are driven.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cl_req_i = 0; ex_req_i = 0; dbg_req_i = 0;
        cl_we_i = 0; ex_we_i = 0; dbg_we_i = 0;
        cl_addr_i = 0; ex_addr_i = 0; dbg_addr_i = 0;
        cl_wdata_i = 0; ex_wdata_i = 0; dbg_wdata_i = 0;
        cl_lock_i = 0;
    endtask

    initial begin
        // Reset with a live request: everything must stay quiet.
        quiet();
        rst = 0;
        csr_rdata_i = 32'h1234_5678;
        cl_req_i = 1; cl_we_i = 1; cl_addr_i = 32'h305; cl_wdata_i = 32'hAAAA_0000;
        #3;
        chk("rst_cl_gnt", cl_gnt_o, 0);
        chk("rst_csr_we", csr_we_o, 0);
        chk("rst_waddr", csr_waddr_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_lock_err", lock_err_o, 0);
        quiet();
        @(posedge clk); #2 rst = 1;

        // All three write mtvec: clint wins.
        nxt();
        cl_req_i = 1; cl_we_i = 1; cl_addr_i = 32'(CSR_MTVEC); cl_wdata_i = 32'h1111_0001;
        ex_req_i = 1; ex_we_i = 1; ex_addr_i = 32'(CSR_MTVEC); ex_wdata_i = 32'h2222_0002;
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 32'(CSR_MTVEC); dbg_wdata_i = 32'h3333_0003;
        #2;
        chk("all_cl_gnt", cl_gnt_o, 1);
        chk("all_ex_gnt", ex_gnt_o, 0);
        chk("all_dbg_gnt", dbg_gnt_o, 0);
        chk("all_we", csr_we_o, 1);
        chk("all_waddr", csr_waddr_o, 32'h305);
        chk("all_wdata", csr_wdata_o, 32'h1111_0001);

        // ex reads mscratch.
        nxt(); quiet();
        ex_req_i = 1; ex_we_i = 0; ex_addr_i = 32'(CSR_MSCRATCH); ex_wdata_i = 32'h0000_00AA;
        csr_rdata_i = 32'hDEAD_BEEF;
        #2;
        chk("rd_ex_gnt", ex_gnt_o, 1);
        chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("rd_we", csr_we_o, 0);
        chk("rd_raddr", csr_raddr_o, 32'h340);
        chk("rd_wdata", csr_wdata_o, 32'h0000_00AA);

        // No request: port idle, rdata forced to 0.
        nxt(); quiet();
        #2;
        chk("idle_rdata", rdata_o, 0);
        chk("idle_raddr", csr_raddr_o, 0);
        chk("idle_gnts", {29'b0, cl_gnt_o, ex_gnt_o, dbg_gnt_o}, 0);

        // ex beats dbg when not starved.
        nxt();
        ex_req_i = 1; dbg_req_i = 1; dbg_addr_i = 32'h7B0;
        #2;
        chk("exdbg_ex_gnt", ex_gnt_o, 1);
        chk("exdbg_dbg_gnt", dbg_gnt_o, 0);
        nxt(); quiet();

        // Trap-entry sequence under lock while ex waits.
        nxt();
        ex_req_i = 1; ex_addr_i = 32'(CSR_MSCRATCH);
        cl_req_i = 1; cl_we_i = 1; cl_lock_i = 1;
        cl_addr_i = 32'(CSR_MEPC); cl_wdata_i = 32'h8000_0040;
        #2;
        chk("lk1_cl_gnt", cl_gnt_o, 1);
        chk("lk1_ex_gnt", ex_gnt_o, 0);
        chk("lk1_waddr", csr_waddr_o, 32'h341);
        nxt();
        cl_addr_i = 32'(CSR_MCAUSE); cl_wdata_i = 32'h8000_000B;
        #2;
        chk("lk2_cl_gnt", cl_gnt_o, 1);
        chk("lk2_ex_gnt", ex_gnt_o, 0);
        chk("lk2_wdata", csr_wdata_o, 32'h8000_000B);
        nxt();
        cl_addr_i = 32'(CSR_MSTATUS); cl_wdata_i = 32'h0000_1800;
        #2;
        chk("lk3_cl_gnt", cl_gnt_o, 1);
        chk("lk3_ex_gnt", ex_gnt_o, 0);
        chk("lk3_waddr", csr_waddr_o, 32'h300);
        nxt();
        cl_req_i = 0; cl_lock_i = 0;
        #2;
        chk("lkdrop_ex_gnt", ex_gnt_o, 0);
        nxt();
        #2;
        chk("lkafter_ex_gnt", ex_gnt_o, 1);
        chk("lkafter_raddr", csr_raddr_o, 32'h340);
        chk("lkafter_err", lock_err_o, 0);
        nxt(); quiet();

        // Starvation: dbg promoted on its 9th consecutive requesting cycle.
        for (int i = 1; i <= 10; i++) begin
            nxt();
            ex_req_i = 1; dbg_req_i = 1; dbg_addr_i = 32'h7B1;
            #2;
            chk($sformatf("starve%0d_dbg", i), dbg_gnt_o, (i == 9) ? 1 : 0);
            chk($sformatf("starve%0d_ex", i), ex_gnt_o, (i == 9) ? 0 : 1);
        end
        nxt(); quiet();

        // Lock timeout: lock held 20 cycles, LOCK_MAX=16.
        nxt();
        cl_req_i = 1; cl_lock_i = 1; cl_addr_i = 32'(CSR_MEPC);
        ex_req_i = 1; ex_addr_i = 32'(CSR_MSCRATCH);
        #2;
        chk("to_enter_cl", cl_gnt_o, 1);
        for (int i = 1; i <= 16; i++) begin
            nxt();
            cl_req_i = 0;
            #2;
            chk($sformatf("to_lk%0d_ex", i), ex_gnt_o, 0);
            chk($sformatf("to_lk%0d_err", i), lock_err_o, 0);
        end
        nxt();
        #2;
        chk("to_err_set", lock_err_o, 1);
        chk("to_ex_gnt", ex_gnt_o, 1);
        // clint re-requests with lock still high: granted, but must not re-lock.
        nxt();
        cl_req_i = 1;
        #2;
        chk("to_cl_again", cl_gnt_o, 1);
        nxt();
        cl_req_i = 0;
        #2;
        chk("to_no_relock_ex", ex_gnt_o, 1);
        nxt(); quiet();
        #2;
        chk("to_err_sticky", lock_err_o, 1);

        // Async reset during LOCKED.
        nxt();
        cl_req_i = 1; cl_lock_i = 1; cl_we_i = 1; cl_addr_i = 32'(CSR_MEPC);
        nxt();
        ex_req_i = 1; ex_addr_i = 32'(CSR_MSCRATCH);
        #2;
        chk("ar_locked_cl", cl_gnt_o, 1);
        chk("ar_locked_ex", ex_gnt_o, 0);
        #2 rst = 0;
        #1;
        chk("ar_cl_gnt", cl_gnt_o, 0);
        chk("ar_ex_gnt", ex_gnt_o, 0);
        chk("ar_csr_we", csr_we_o, 0);
        chk("ar_rdata", rdata_o, 0);
        chk("ar_lock_err", lock_err_o, 0);
        @(posedge clk);
        #3 rst = 1;
        cl_req_i = 0; cl_lock_i = 0; cl_we_i = 0;
        #1;
        chk("ar_rel_ex_gnt", ex_gnt_o, 1);
        nxt();
        cl_req_i = 1;
        #2;
        chk("ar_rel_cl_gnt", cl_gnt_o, 1);
        chk("ar_rel_ex_lose", ex_gnt_o, 0);
        nxt(); quiet();
        #2;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
